// File: rtl/execution_unit_multi_cycle_pkg.sv
// Shared opcodes and divider state encoding
// for the multi-cycle execution unit.
package execution_unit_multi_cycle_pkg;

  localparam logic [5:0] OP_ADD    = 6'd0;
  localparam logic [5:0] OP_SLT    = 6'd2;
  localparam logic [5:0] OP_SLTU   = 6'd3;
  localparam logic [5:0] OP_XOR    = 6'd4;
  localparam logic [5:0] OP_OR     = 6'd6;
  localparam logic [5:0] OP_SLL    = 6'd8;
  localparam logic [5:0] OP_AND    = 6'd10;
  localparam logic [5:0] OP_SRL    = 6'd12;
  localparam logic [5:0] OP_SRA    = 6'd13;
  localparam logic [5:0] OP_SUB    = 6'd14;
  localparam logic [5:0] OP_MUL    = 6'd20;
  localparam logic [5:0] OP_MULH   = 6'd21;
  localparam logic [5:0] OP_MULHSU = 6'd22;
  localparam logic [5:0] OP_MULHU  = 6'd23;
  localparam logic [5:0] OP_BEQ    = 6'd24;
  localparam logic [5:0] OP_BNE    = 6'd25;
  localparam logic [5:0] OP_BLT    = 6'd26;
  localparam logic [5:0] OP_BGE    = 6'd27;
  localparam logic [5:0] OP_BLTU   = 6'd28;
  localparam logic [5:0] OP_BGEU   = 6'd29;
  localparam logic [5:0] OP_DIV    = 6'd32;
  localparam logic [5:0] OP_DIVU   = 6'd33;
  localparam logic [5:0] OP_REM    = 6'd34;
  localparam logic [5:0] OP_REMU   = 6'd35;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/execution_unit_multi_cycle_divider.sv
// Restoring divider, one quotient bit per
// cycle, with signed/unsigned operation.
module divider_iterative
  import execution_unit_multi_cycle_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         clear,
  input  logic         is_signed,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W);

  div_state_t    state, state_n;
  logic [CW-1:0] count;
  logic [W-1:0]  r, q, d, a_q;
  logic          neg_q, neg_r, dz;
  logic [W:0]    trial;
  logic [W-1:0]  a_mag, b_mag;

  assign a_mag = (is_signed && dividend[W-1])
               ? -dividend : dividend;
  assign b_mag = (is_signed && divisor[W-1])
               ? -divisor : divisor;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = BUSY;
      BUSY: if (count == CW'(W-1)) state_n = DONE;
      DONE: if (clear) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign trial = {r, q[W-1]} - {1'b0, d};

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      r     <= '0;
      q     <= '0;
      d     <= '0;
      a_q   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
    end else if (state == IDLE && start) begin
      count <= '0;
      r     <= '0;
      q     <= a_mag;
      d     <= b_mag;
      a_q   <= dividend;
      dz    <= (divisor == '0);
      neg_q <= is_signed
             & (dividend[W-1] ^ divisor[W-1]);
      neg_r <= is_signed & dividend[W-1];
    end else if (state == BUSY) begin
      count <= count + 1'b1;
      q     <= {q[W-2:0], ~trial[W]};
      r     <= trial[W] ? {r[W-2:0], q[W-1]}
                        : trial[W-1:0];
    end
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

  // Zero divisor bypasses sign fix-up entirely
  assign quotient  = dz    ? '1
                   : neg_q ? -q : q;
  assign remainder = dz    ? a_q
                   : neg_r ? -r : r;

endmodule

// File: rtl/execution_unit_multi_cycle.sv
// Execution unit: single-cycle ALU, branch,
// multiply, and an iterative divider.
module execution_unit_multi_cycle
  import execution_unit_multi_cycle_pkg::*;
#(
  parameter int    CORE         = 0,
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDRESS_BITS = 20,
  parameter string M_EXTENSION  = "True"
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [5:0]              ALU_operation,
  input  logic [ADDRESS_BITS-1:0] PC,
  input  logic [1:0]              operand_A_sel,
  input  logic                    operand_B_sel,
  input  logic                    branch_op,
  input  logic [DATA_WIDTH-1:0]   rs1_data,
  input  logic [DATA_WIDTH-1:0]   rs2_data,
  input  logic [DATA_WIDTH-1:0]   extend,
  input  logic                    ready_i,
  output logic                    ready_o,
  output logic                    valid_result,
  output logic                    branch,
  output logic [DATA_WIDTH-1:0]   ALU_result,
  output logic [ADDRESS_BITS-1:0] JALR_target,
  input  logic                    scan
);

  localparam int W    = DATA_WIDTH;
  localparam bit M_EN = (M_EXTENSION == "True");

  logic [W-1:0]   a, b, pc_ext;
  logic [4:0]     shamt;
  logic [2*W-1:0] sa, sb, za, zb;
  logic [2*W-1:0] mul_ss, mul_su, mul_uu;
  logic [W-1:0]   jalr_sum;
  logic           is_br, cond, is_div;
  logic           div_busy, div_done;
  logic           div_start, div_clear;
  logic           div_signed;
  logic [W-1:0]   div_q, div_r, div_res;
  logic [5:0]     op_q;
  logic           unused_bits;

  assign pc_ext = W'(PC);

  always_comb begin
    a = rs1_data;
    unique case (operand_A_sel)
      2'd1:    a = pc_ext;
      2'd2:    a = pc_ext + W'(4);
      default: a = rs1_data;
    endcase
  end

  assign b     = operand_B_sel ? extend : rs2_data;
  assign shamt = b[4:0];

  assign sa = {{W{a[W-1]}}, a};
  assign sb = {{W{b[W-1]}}, b};
  assign za = {{W{1'b0}}, a};
  assign zb = {{W{1'b0}}, b};
  assign mul_ss = sa * sb;
  assign mul_su = sa * zb;
  assign mul_uu = za * zb;

  assign jalr_sum    = rs1_data + extend;
  assign JALR_target =
    {jalr_sum[ADDRESS_BITS-1:1], 1'b0};

  assign is_div = ALU_operation inside
    {OP_DIV, OP_DIVU, OP_REM, OP_REMU};

  always_comb begin
    is_br = 1'b1;
    cond  = 1'b0;
    unique case (ALU_operation)
      OP_BEQ:  cond = (a == b);
      OP_BNE:  cond = (a != b);
      OP_BLT:  cond = $signed(a) < $signed(b);
      OP_BGE:  cond = $signed(a) >= $signed(b);
      OP_BLTU: cond = a < b;
      OP_BGEU: cond = a >= b;
      default: is_br = 1'b0;
    endcase
  end

  assign branch = branch_op & is_br & cond;

  always_comb begin
    ALU_result = '0;
    unique case (ALU_operation)
      OP_ADD:  ALU_result = a + b;
      OP_SUB:  ALU_result = a - b;
      OP_SLT:  ALU_result =
        W'($signed(a) < $signed(b));
      OP_SLTU: ALU_result = W'(a < b);
      OP_XOR:  ALU_result = a ^ b;
      OP_OR:   ALU_result = a | b;
      OP_AND:  ALU_result = a & b;
      OP_SLL:  ALU_result = a << shamt;
      OP_SRL:  ALU_result = a >> shamt;
      OP_SRA:  ALU_result =
        W'($signed(a) >>> shamt);
      OP_MUL:    if (M_EN)
        ALU_result = mul_ss[W-1:0];
      OP_MULH:   if (M_EN)
        ALU_result = mul_ss[2*W-1:W];
      OP_MULHSU: if (M_EN)
        ALU_result = mul_su[2*W-1:W];
      OP_MULHU:  if (M_EN)
        ALU_result = mul_uu[2*W-1:W];
      OP_DIV, OP_DIVU, OP_REM, OP_REMU:
        if (M_EN && div_done)
          ALU_result = div_res;
      default: ALU_result = is_br ? W'(cond) : '0;
    endcase
  end

  assign div_start  = M_EN & ready_i & is_div;
  assign div_clear  = ready_i | (ALU_operation != op_q);
  assign div_signed = (ALU_operation == OP_DIV)
                    | (ALU_operation == OP_REM);

  // Opcode of the running division picks q or r
  always_ff @(posedge clock) begin
    if (reset)
      op_q <= '0;
    else if (div_start && !div_busy && !div_done)
      op_q <= ALU_operation;
  end

  assign div_res = (op_q == OP_REM || op_q == OP_REMU)
                 ? div_r : div_q;

  if (M_EN) begin : g_div
    divider_iterative #(.W(W)) u_div (
      .clock     (clock),
      .reset     (reset),
      .start     (div_start),
      .clear     (div_clear),
      .is_signed (div_signed),
      .dividend  (a),
      .divisor   (b),
      .busy      (div_busy),
      .done      (div_done),
      .quotient  (div_q),
      .remainder (div_r)
    );
  end else begin : g_nodiv
    assign div_busy = 1'b0;
    assign div_done = 1'b0;
    assign div_q    = '0;
    assign div_r    = '0;
  end

  assign ready_o      = ~div_busy;
  assign valid_result = (M_EN && is_div) ? div_done : 1'b1;

  assign unused_bits = ^{scan,
    jalr_sum[W-1:ADDRESS_BITS], jalr_sum[0],
    mul_su[W-1:0], mul_uu[W-1:0]};

endmodule

// File: tb/tb_execution_unit_multi_cycle.sv
// Directed bench for the execution unit:
// ALU, branch, multiply, JALR and divider.
module tb_execution_unit_multi_cycle;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  ALU_operation;
  logic [19:0] PC;
  logic [1:0]  operand_A_sel;
  logic        operand_B_sel;
  logic        branch_op;
  logic [31:0] rs1_data, rs2_data, extend;
  logic        ready_i;
  logic        ready_o, valid_result, branch;
  logic [31:0] ALU_result;
  logic [19:0] JALR_target;
  logic        scan;

  int checks = 0;
  int failures = 0;

  execution_unit_multi_cycle dut (
    .clock         (clock),
    .reset         (reset),
    .ALU_operation (ALU_operation),
    .PC            (PC),
    .operand_A_sel (operand_A_sel),
    .operand_B_sel (operand_B_sel),
    .branch_op     (branch_op),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .extend        (extend),
    .ready_i       (ready_i),
    .ready_o       (ready_o),
    .valid_result  (valid_result),
    .branch        (branch),
    .ALU_result    (ALU_result),
    .JALR_target   (JALR_target),
    .scan          (scan)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic alu(input string tag,
                     input logic [5:0] op,
                     input logic [31:0] x,
                     input logic [31:0] y,
                     input logic [31:0] exp);
    ALU_operation = op;
    rs1_data      = x;
    rs2_data      = y;
    operand_A_sel = 2'd0;
    operand_B_sel = 1'b0;
    #1;
    chk(tag, ALU_result, exp);
  endtask

  task automatic div_run(input string tag,
                         input logic [5:0] op,
                         input logic [31:0] x,
                         input logic [31:0] y,
                         input logic [31:0] exp);
    int cyc;
    @(negedge clock);
    ALU_operation = op;
    rs1_data      = x;
    rs2_data      = y;
    operand_A_sel = 2'd0;
    operand_B_sel = 1'b0;
    ready_i       = 1'b1;
    #1;
    chk({tag, "_idle_valid"}, 32'(valid_result), 32'd0);
    @(posedge clock);
    #1;
    ready_i  = 1'b0;
    rs1_data = 32'h1234_5678;
    rs2_data = 32'h0000_0003;
    cyc = 0;
    while (!ready_o && cyc < 100) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'd32);
    chk({tag, "_valid"}, 32'(valid_result), 32'd1);
    chk({tag, "_res"}, ALU_result, exp);
    @(negedge clock);
    ALU_operation = 6'd0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    ALU_operation = 6'd0;
    PC            = 20'h0;
    operand_A_sel = 2'd0;
    operand_B_sel = 1'b0;
    branch_op     = 1'b0;
    rs1_data      = 32'd2;
    rs2_data      = 32'd3;
    extend        = 32'd0;
    scan          = 1'b0;
    ready_i       = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(valid_result), 32'd1);
    chk("rst_comb_add", ALU_result, 32'd5);
    reset = 1'b0;
    @(posedge clock);
    #1;

    alu("srl", 6'd12, 32'd15, 32'd2, 32'h3);
    alu("sub", 6'd14, 32'd5, 32'd7, 32'hFFFF_FFFE);
    ALU_operation = 6'd10;
    rs1_data      = 32'd4;
    rs2_data      = 32'd7;
    extend        = 32'd4;
    operand_B_sel = 1'b1;
    #1;
    chk("and_imm", ALU_result, 32'd4);
    alu("mul", 6'd20, 32'd4, 32'd7, 32'd28);
    chk("mul_valid", 32'(valid_result), 32'd1);
    alu("add", 6'd0, 32'hFFFF_FFFF, 32'd2, 32'd1);
    alu("slt", 6'd2, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu("sltu", 6'd3, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu("xor", 6'd4, 32'hF0F0_00FF, 32'h0FF0_0F0F,
        32'hFF00_0FF0);
    alu("or", 6'd6, 32'hF000_0000, 32'h0000_000F,
        32'hF000_000F);
    alu("sll31", 6'd8, 32'd1, 32'h0000_003F,
        32'h8000_0000);
    alu("sra", 6'd13, 32'h8000_0000, 32'd4,
        32'hF800_0000);
    alu("mulh", 6'd21, 32'hFFFF_FFFE, 32'd3,
        32'hFFFF_FFFF);
    alu("mulhsu", 6'd22, 32'hFFFF_FFFF,
        32'hFFFF_FFFF, 32'hFFFF_FFFF);
    alu("mulhu", 6'd23, 32'hFFFF_FFFF,
        32'hFFFF_FFFF, 32'hFFFF_FFFE);
    alu("unlisted", 6'd1, 32'd9, 32'd9, 32'd0);
    chk("unlisted_br", 32'(branch), 32'd0);

    branch_op = 1'b1;
    alu("blt_res", 6'd26, 32'hFFFF_FFFF, 32'd1, 32'd1);
    chk("blt_br", 32'(branch), 32'd1);
    alu("bltu_res", 6'd28, 32'hFFFF_FFFF, 32'd1, 32'd0);
    chk("bltu_br", 32'(branch), 32'd0);
    alu("bne_res", 6'd25, 32'd3, 32'd3, 32'd0);
    chk("bne_br", 32'(branch), 32'd0);
    branch_op = 1'b0;
    alu("beq_nobr", 6'd24, 32'd3, 32'd3, 32'd1);
    chk("beq_nobr_br", 32'(branch), 32'd0);

    rs1_data = 32'h101;
    extend   = 32'd4;
    #1;
    chk("jalr", 32'(JALR_target), 32'h104);

    PC            = 20'h100;
    ALU_operation = 6'd0;
    rs2_data      = 32'd0;
    operand_A_sel = 2'd1;
    #1;
    chk("pc_sel", ALU_result, 32'h100);
    operand_A_sel = 2'd2;
    #1;
    chk("pc4_sel", ALU_result, 32'h104);
    operand_A_sel = 2'd0;

    div_run("div", 6'd32, -32'sd100, 32'd7,
            32'hFFFF_FFF2);
    div_run("rem", 6'd34, -32'sd100, 32'd7,
            32'hFFFF_FFFE);
    div_run("divu", 6'd33, 32'd100, 32'd7, 32'd14);
    div_run("remu", 6'd35, 32'd100, 32'd7, 32'd2);
    div_run("div0", 6'd32, 32'd55, 32'd0,
            32'hFFFF_FFFF);
    div_run("remu0", 6'd35, 32'd123, 32'd0, 32'd123);
    div_run("ovf_q", 6'd32, 32'h8000_0000,
            32'hFFFF_FFFF, 32'h8000_0000);
    div_run("ovf_r", 6'd34, 32'h8000_0000,
            32'hFFFF_FFFF, 32'd0);

    @(negedge clock);
    ALU_operation = 6'd32;
    rs1_data      = 32'd50;
    rs2_data      = 32'd5;
    ready_i       = 1'b1;
    @(posedge clock);
    #1;
    ready_i = 1'b0;
    chk("busy_ready", 32'(ready_o), 32'd0);
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("abort_ready", 32'(ready_o), 32'd1);
    chk("abort_valid", 32'(valid_result), 32'd0);
    reset         = 1'b0;
    ALU_operation = 6'd0;
    @(posedge clock);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
